// File: rtl/usb_tx_fifo_pkg.sv
// USB TX FIFO shared definitions.
// Pointer type, count width and control priority.
package usb_tx_fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int COUNT_WIDTH = 16;

  // Pointer for the default 64-entry build; MSB is the wrap bit.
  typedef logic [DEF_ADDR_WIDTH:0] fifoPtr_t;

  // Control priority, highest first.
  typedef enum logic [1:0] {
    PRIO_RESET = 2'd0,
    PRIO_FLUSH = 2'd1,
    PRIO_READ  = 2'd2,
    PRIO_WRITE = 2'd3
  } fifoPrio_e;

  localparam fifoPrio_e FORCE_EMPTY_PRIORITY = PRIO_FLUSH;

endpackage

// File: rtl/usb_fifo_dpram.sv
// Simple dual-port RAM, one write port.
// Registered read port for block RAM mapping.
module usb_fifo_dpram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  usbClk,
  input  logic                  rstSync,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0] rdData
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array write, contents never reset.
  always_ff @(posedge usbClk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Registered read; holds until next enabled read.
  always_ff @(posedge usbClk) begin
    if (rstSync) begin
      rdData <= '0;
    end else if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/usb_tx_fifo_core.sv
// USB transmit byte FIFO, single clock.
// Pointers, count and flags around a DPRAM.
module usb_tx_fifo_core
  import usb_tx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   usbClk,
  input  logic                   rstSyncToUsbClk,
  input  logic [DATA_WIDTH-1:0]  dataIn,
  input  logic                   fifoWEn,
  input  logic                   forceEmpty,
  input  logic                   fifoREn,
  output logic [DATA_WIDTH-1:0]  dataOut,
  output logic                   fifoFull,
  output logic                   fifoEmpty,
  output logic [COUNT_WIDTH-1:0] numElementsInFifo
);

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t DEPTH_CNT = ptr_t'(FIFO_DEPTH);
  localparam bit FLUSH_OVER_RW =
    (FORCE_EMPTY_PRIORITY < PRIO_READ);

  ptr_t wrPtr;
  ptr_t rdPtr;
  ptr_t count;
  ptr_t countNext;
  logic fullReg;
  logic emptyReg;
  logic flushCut;
  logic wrAccept;
  logic rdAccept;

  assign flushCut = FLUSH_OVER_RW && forceEmpty;
  assign wrAccept = fifoWEn && !fullReg && !flushCut;
  assign rdAccept = fifoREn && !emptyReg && !flushCut;

  // Next occupancy from the accepted strobes.
  always_comb begin
    countNext = count;
    unique case (1'b1)
      wrAccept && !rdAccept: countNext = count + 1'b1;
      rdAccept && !wrAccept: countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // Pointer, count and flag registers; flush beats strobes.
  always_ff @(posedge usbClk) begin
    if (rstSyncToUsbClk) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      fullReg  <= 1'b0;
      emptyReg <= 1'b1;
    end else if (forceEmpty) begin
      rdPtr    <= wrPtr;
      count    <= '0;
      fullReg  <= 1'b0;
      emptyReg <= 1'b1;
    end else begin
      if (wrAccept) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (rdAccept) begin
        rdPtr <= rdPtr + 1'b1;
      end
      count    <= countNext;
      fullReg  <= (countNext == DEPTH_CNT);
      emptyReg <= (countNext == '0);
    end
  end

  usb_fifo_dpram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) uRam (
    .usbClk  (usbClk),
    .rstSync (rstSyncToUsbClk),
    .wrEn    (wrAccept),
    .wrAddr  (wrPtr[ADDR_WIDTH-1:0]),
    .wrData  (dataIn),
    .rdEn    (rdAccept),
    .rdAddr  (rdPtr[ADDR_WIDTH-1:0]),
    .rdData  (dataOut)
  );

  assign fifoFull  = fullReg;
  assign fifoEmpty = emptyReg;
  assign numElementsInFifo =
    {{(COUNT_WIDTH-ADDR_WIDTH-1){1'b0}}, count};

endmodule

// File: tb/tb_usb_tx_fifo_core.sv
// Directed bench for usb_tx_fifo_core.
// Drives and samples 1 ns after each rising edge.
module tb_usb_tx_fifo_core;

  logic        usbClk = 1'b0;
  logic        rst;
  logic [7:0]  dataIn;
  logic        fifoWEn;
  logic        forceEmpty;
  logic        fifoREn;
  logic [7:0]  dataOut;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [15:0] numElementsInFifo;

  int nAsserts = 0;
  int nFails = 0;

  usb_tx_fifo_core #(
    .FIFO_DEPTH (64),
    .ADDR_WIDTH (6),
    .DATA_WIDTH (8)
  ) dut (
    .usbClk            (usbClk),
    .rstSyncToUsbClk   (rst),
    .dataIn            (dataIn),
    .fifoWEn           (fifoWEn),
    .forceEmpty        (forceEmpty),
    .fifoREn           (fifoREn),
    .dataOut           (dataOut),
    .fifoFull          (fifoFull),
    .fifoEmpty         (fifoEmpty),
    .numElementsInFifo (numElementsInFifo)
  );

  always #5 usbClk = ~usbClk;

  task automatic tick();
    @(posedge usbClk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chkState(input string tag,
                          input int cnt,
                          input logic full,
                          input logic empty);
    chk({tag, "_count"}, 32'(numElementsInFifo), 32'(cnt));
    chk({tag, "_full"}, 32'(fifoFull), 32'(full));
    chk({tag, "_empty"}, 32'(fifoEmpty), 32'(empty));
  endtask

  initial begin
    rst = 1'b1;
    dataIn = 8'h00;
    fifoWEn = 1'b0;
    forceEmpty = 1'b0;
    fifoREn = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chkState("reset", 0, 1'b0, 1'b1);
    chk("reset_dout", 32'(dataOut), 32'h00);

    // three writes then three reads
    fifoWEn = 1'b1;
    dataIn = 8'h11;
    tick();
    dataIn = 8'h22;
    tick();
    dataIn = 8'h33;
    tick();
    fifoWEn = 1'b0;
    chkState("w3", 3, 1'b0, 1'b0);
    chk("w3_dout", 32'(dataOut), 32'h00);
    fifoREn = 1'b1;
    tick();
    chk("r1_dout", 32'(dataOut), 32'h11);
    chk("r1_count", 32'(numElementsInFifo), 32'd2);
    tick();
    chk("r2_dout", 32'(dataOut), 32'h22);
    tick();
    chk("r3_dout", 32'(dataOut), 32'h33);
    fifoREn = 1'b0;
    chkState("r3", 0, 1'b0, 1'b1);

    // fill to 64, pointers start at 3
    fifoWEn = 1'b1;
    for (int i = 0; i < 64; i++) begin
      dataIn = 8'(i);
      tick();
      if (i == 62) chkState("fill63", 63, 1'b0, 1'b0);
    end
    chkState("fill64", 64, 1'b1, 1'b0);
    dataIn = 8'hAA;
    tick();
    fifoWEn = 1'b0;
    chkState("wfull", 64, 1'b1, 1'b0);
    chk("wfull_dout", 32'(dataOut), 32'h33);

    // read and write together at full: only read
    fifoWEn = 1'b1;
    fifoREn = 1'b1;
    dataIn = 8'hBB;
    tick();
    fifoWEn = 1'b0;
    fifoREn = 1'b0;
    chkState("rwfull", 63, 1'b0, 1'b0);
    chk("rwfull_dout", 32'(dataOut), 32'h00);
    fifoREn = 1'b1;
    for (int i = 1; i < 64; i++) begin
      tick();
      chk("drain_dout", 32'(dataOut), 32'(i));
    end
    fifoREn = 1'b0;
    chkState("drain", 0, 1'b0, 1'b1);

    // read on empty
    fifoREn = 1'b1;
    tick();
    fifoREn = 1'b0;
    chkState("rempty", 0, 1'b0, 1'b1);
    chk("rempty_dout", 32'(dataOut), 32'h3F);

    // empty, read and write together: write only
    fifoWEn = 1'b1;
    fifoREn = 1'b1;
    dataIn = 8'h77;
    tick();
    fifoWEn = 1'b0;
    chkState("rwempty", 1, 1'b0, 1'b0);
    chk("rwempty_dout", 32'(dataOut), 32'h3F);
    tick();
    fifoREn = 1'b0;
    chk("rwempty_next", 32'(dataOut), 32'h77);
    chkState("rwempty2", 0, 1'b0, 1'b1);

    // move pointers to address 4, then to 63
    fifoWEn = 1'b1;
    fifoREn = 1'b1;
    for (int i = 0; i < 59; i++) begin
      dataIn = 8'h01;
      fifoREn = (i != 0);
      tick();
    end
    fifoWEn = 1'b0;
    tick();
    fifoREn = 1'b0;
    chkState("filler", 0, 1'b0, 1'b1);

    // preload 5 so writes cross 63->0
    fifoWEn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dataIn = 8'hC0 + 8'(i);
      tick();
    end
    chkState("pre5", 5, 1'b0, 1'b0);
    fifoREn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dataIn = 8'hD0 + 8'(i);
      tick();
      chk("sim_count", 32'(numElementsInFifo), 32'd5);
      chk("sim_dout", 32'(dataOut),
          (i < 5) ? 32'hC0 + 32'(i) : 32'hD0 + 32'(i - 5));
    end
    fifoWEn = 1'b0;
    for (int i = 5; i < 10; i++) begin
      tick();
      chk("tail_dout", 32'(dataOut), 32'hD0 + 32'(i));
    end
    fifoREn = 1'b0;
    chkState("tail", 0, 1'b0, 1'b1);

    // count 10, then flush with a write
    fifoWEn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dataIn = 8'hE0 + 8'(i);
      tick();
    end
    chkState("pre10", 10, 1'b0, 1'b0);
    forceEmpty = 1'b1;
    dataIn = 8'h55;
    tick();
    forceEmpty = 1'b0;
    fifoWEn = 1'b0;
    chkState("flush", 0, 1'b0, 1'b1);
    chk("flush_dout", 32'(dataOut), 32'hD9);
    fifoWEn = 1'b1;
    dataIn = 8'h66;
    tick();
    fifoWEn = 1'b0;
    chkState("post_w", 1, 1'b0, 1'b0);
    fifoREn = 1'b1;
    tick();
    fifoREn = 1'b0;
    chk("post_dout", 32'(dataOut), 32'h66);
    chkState("post_r", 0, 1'b0, 1'b1);

    // flush while empty, with a read
    forceEmpty = 1'b1;
    fifoREn = 1'b1;
    tick();
    forceEmpty = 1'b0;
    fifoREn = 1'b0;
    chkState("flush_e", 0, 1'b0, 1'b1);
    chk("flush_e_dout", 32'(dataOut), 32'h66);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFails);
    $finish;
  end

endmodule
